// File: rtl/conv_window_five.sv
// Streaming 5x5 window generator: raster pixels in, every fully-populated 5x5 window out.
// Four line buffers hold the previous rows; a 5x5 shift register holds the window under
// construction; a single output register presents windows on a valid/ready handshake.
module conv_window_five #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic [7:0]   pix_data,
  output logic         win_valid,
  input  logic         win_ready,
  output logic [199:0] win_data,
  output logic         win_last
);

  localparam int unsigned AW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [AW-1:0] ColLast = AW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
  localparam logic [AW-1:0] ColFirstWin = AW'(4);
  localparam logic [RW-1:0] RowFirstWin = RW'(4);

  // Position of the next pixel to be accepted
  logic [AW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // lb_q[0] holds row r-4, lb_q[3] holds row r-1 (relative to the incoming row)
  logic [7:0] lb_q [4][IMG_W];
  logic [7:0] lb_rd [4];

  // win_q[i][j]: i = 0 top row, j = 0 leftmost column
  logic [7:0] win_q [5][5];
  logic [7:0] win_d [5][5];
  logic [7:0] new_col [5];
  logic [199:0] win_flat;

  logic [199:0] win_data_q, win_data_d;
  logic         win_valid_q, win_valid_d;
  logic         win_last_q, win_last_d;

  logic accept;
  logic fire;
  logic at_frame_end;

  // Handshake decode; readiness only depends on the output register draining
  always_comb begin
    pix_ready    = ~win_valid_q | win_ready;
    accept       = pix_valid & pix_ready & ~clr;
    fire         = accept & (row_q >= RowFirstWin) & (col_q >= ColFirstWin);
    at_frame_end = (row_q == RowLast) & (col_q == ColLast);
  end

  // Read the stored column at the current x position and form the incoming window column
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lb_rd[k] = lb_q[k][col_q];
    end
    for (int k = 0; k < 4; k++) begin
      new_col[k] = lb_rd[k];
    end
    new_col[4] = pix_data;
  end

  // Row/column counters advance only on accepted pixels; clr restarts the frame
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + AW'(1);
      end
    end
  end

  // Counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers shift one column up on accept; contents are deliberately never cleared
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][col_q] <= lb_rd[1];
      lb_q[1][col_q] <= lb_rd[2];
      lb_q[2][col_q] <= lb_rd[3];
      lb_q[3][col_q] <= pix_data;
    end
  end

  // Shift window left by one and append the new column on the right
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][4] = new_col[i];
      end
    end
  end

  // Window shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  // Flatten the post-shift window so a firing pixel lands as element (5,5)
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        win_flat[8*(5*i+j) +: 8] = win_d[i][j];
      end
    end
  end

  // Output register: load on fire, drop on consume, load wins over a simultaneous consume
  always_comb begin
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_data_d  = win_data_q;
    if (clr) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
      win_data_d  = '0;
    end else if (fire) begin
      win_valid_d = 1'b1;
      win_last_d  = at_frame_end;
      win_data_d  = win_flat;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // Output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_data_q  <= '0;
    end else begin
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_data_q  <= win_data_d;
    end
  end

  // Output drive
  always_comb begin
    win_valid = win_valid_q;
    win_last  = win_last_q;
    win_data  = win_data_q;
  end

endmodule

// File: tb/tb_conv_window_five.sv
// Self-checking bench for conv_window_five on an 8x6 image with pixel = 16*row+col.
`timescale 1ns/1ps
module tb_conv_window_five;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NW = (W - 4) * (H - 4);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_data = '0;
  logic         win_ready = 1'b1;
  logic         pix_ready;
  logic         win_valid;
  logic         win_last;
  logic [199:0] win_data;

  conv_window_five #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [200:0] got[$];
  bit stall_probe = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int p);
    return 8'(16 * (p / W) + (p % W));
  endfunction

  // k-th window of a frame straight from the image formula
  function automatic logic [199:0] golden(input int k);
    int wr = 4 + (k % NW) / (W - 4);
    int wc = 4 + (k % NW) % (W - 4);
    logic [199:0] g = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        g[8*(5*i+j) +: 8] = 8'(16 * (wr - 4 + i) + (wc - 4 + j));
    return g;
  endfunction

  // Reference model: image array plus expected output register contents
  logic [7:0]   img [H][W];
  int           mr, mc;
  bit           exp_valid, exp_last, m_acc;
  logic [199:0] exp_data;

  always @(posedge clk or negedge rst_n) begin
    bit fired;
    fired = 0;
    if (!rst_n) begin
      mr = 0; mc = 0; exp_valid = 0; exp_last = 0; exp_data = '0; m_acc = 0;
    end else begin
      m_acc = pix_valid && (!exp_valid || win_ready) && !clr;
      if (clr) begin
        mr = 0; mc = 0; exp_valid = 0; exp_last = 0;
      end else begin
        if (m_acc) begin
          img[mr][mc] = pix_data;
          if (mr >= 4 && mc >= 4) begin
            for (int i = 0; i < 5; i++)
              for (int j = 0; j < 5; j++)
                exp_data[8*(5*i+j) +: 8] = img[mr-4+i][mc-4+j];
            exp_last  = (mr == H - 1) && (mc == W - 1);
            exp_valid = 1;
            fired = 1;
          end
          mc++;
          if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
          end
        end
        if (!fired && win_ready) exp_valid = 0;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of consumed windows
  always @(negedge clk) begin
    if (rst_n) begin
      chk("win_valid", 200'(win_valid), 200'(exp_valid));
      chk("pix_ready", 200'(pix_ready), 200'(!exp_valid || win_ready));
      if (exp_valid) begin
        chk("win_data", win_data, exp_data);
        chk("win_last", 200'(win_last), 200'(exp_last));
      end
      if (win_valid && win_ready) got.push_back({win_last, win_data});
      if (stall_probe) begin
        stall_probe = 0;
        chk("stall valid", 200'(win_valid), 200'(1));
        chk("stall byte24", 200'(win_data[199:192]), 200'(8'h44));
        chk("stall byte0", 200'(win_data[7:0]), 200'(8'h00));
        chk("stall pix_ready", 200'(pix_ready), 200'(0));
      end
    end
  end

  // Drive one frame. mode: 0 ready=1, 1 random ready, 2 ten-cycle stall after first window,
  // 3 ready=0. Stops early at pixel index stop_at, optionally asserting clr with it.
  task automatic send(input int gap, input int mode, input int stop_at, input bit do_clr);
    int p = 0;
    int guard = 0;
    int stall_left = 0;
    bit stall_done = 0;
    bit holding = 0;
    while (1) begin
      if (p == stop_at) begin
        if (do_clr) begin
          clr = 1; pix_valid = 1; pix_data = pv(p);
          @(posedge clk); #1;
          clr = 0;
        end
        pix_valid = 0;
        break;
      end
      case (mode)
        0: win_ready = 1;
        1: win_ready = 1'($urandom_range(1));
        2: begin
          if (stall_left > 0) begin
            win_ready = 0;
            stall_left--;
            if (stall_left == 5) stall_probe = 1;
          end else if (!stall_done && win_valid) begin
            stall_done = 1; stall_left = 9; win_ready = 0;
          end else begin
            win_ready = 1;
          end
        end
        default: win_ready = 0;
      endcase
      if (!holding) begin
        pix_valid = ($urandom_range(99) >= gap);
        pix_data  = pv(p);
        holding   = pix_valid;
      end
      @(posedge clk); #1;
      if (m_acc) begin
        p++;
        holding = 0;
        if (p == W * H) break;
      end
      guard++;
      if (guard > 3000) begin
        checks++; failures++;
        $display("FAIL driver timeout: stuck at pixel %0d", p);
        break;
      end
    end
  endtask

  task automatic drain();
    pix_valid = 0;
    win_ready = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input int nframes, input string tag);
    int nl = 0;
    chk($sformatf("%s count", tag), 200'(got.size()), 200'(NW * nframes));
    for (int k = 0; k < got.size() && k < NW * nframes; k++) begin
      chk($sformatf("%s win%0d data", tag, k), got[k][199:0], golden(k));
      chk($sformatf("%s win%0d last", tag, k), 200'(got[k][200]), 200'(k % NW == NW - 1));
      nl += int'(got[k][200]);
    end
    chk($sformatf("%s last count", tag), 200'(nl), 200'(nframes));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset win_valid", 200'(win_valid), 200'(0));
    chk("reset win_last", 200'(win_last), 200'(0));
    chk("reset win_data", win_data, 200'(0));
    chk("reset pix_ready", 200'(pix_ready), 200'(1));
    rst_n = 1;

    got.delete(); send(0, 0, -1, 0); drain(); check_log(1, "plain");
    if (got.size() >= NW) begin
      chk("first byte0", 200'(got[0][7:0]), 200'(8'h00));
      chk("first byte4", 200'(got[0][39:32]), 200'(8'h04));
      chk("first byte20", 200'(got[0][167:160]), 200'(8'h40));
      chk("first byte24", 200'(got[0][199:192]), 200'(8'h44));
      chk("last byte24", 200'(got[NW-1][199:192]), 200'(8'h57));
      chk("last byte0", 200'(got[NW-1][7:0]), 200'(8'h13));
      chk("last flag", 200'(got[NW-1][200]), 200'(1));
    end

    got.delete(); send(0, 2, -1, 0); drain(); check_log(1, "stall");
    got.delete(); send(50, 1, -1, 0); drain(); check_log(1, "random");

    got.delete(); send(0, 0, -1, 0); send(0, 0, -1, 0); drain(); check_log(2, "b2b");
    if (got.size() > NW) begin
      chk("frame2 byte24", 200'(got[NW][199:192]), 200'(8'h44));
      chk("frame2 byte0", 200'(got[NW][7:0]), 200'(8'h00));
    end

    got.delete(); send(0, 0, 3 * W + 2, 1); send(0, 0, -1, 0); drain(); check_log(1, "clr");

    got.delete(); send(0, 3, 4 * W + 5, 0);
    chk("pre-rst win_valid", 200'(win_valid), 200'(1));
    #2 rst_n = 0;
    #1;
    chk("rst win_valid", 200'(win_valid), 200'(0));
    chk("rst win_data", win_data, 200'(0));
    chk("rst win_last", 200'(win_last), 200'(0));
    @(posedge clk); #1;
    rst_n = 1;
    got.delete(); send(0, 0, -1, 0); drain(); check_log(1, "rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_five.md
# conv_window_five

Streaming 5x5 window generator that feeds the 5x5 convolution MAC kernel. It accepts one 8-bit pixel per cycle in raster order and buffers four previous image rows in on-chip line buffers. It emits every fully-populated 5x5 window (valid convolution, no padding) as a flattened 25-byte vector, using a valid/ready handshake on both sides.

## Interface
- IMG_W, 28, image width in pixels (5..256)
- IMG_H, 28, image height in rows (5..256)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous frame restart; clears row/col counters and output register
- pix_valid  in  1  pixel present on pix_data
- pix_ready  out  1  block can accept a pixel this cycle
- pix_data  in  8  unsigned pixel, raster order (row 0 col 0 first)
- win_valid  out  1  win_data holds a complete window
- win_ready  in  1  consumer takes window this cycle
- win_data  out  200  window; byte k = win_data[8k+7:8k], k = 5*(i-1)+(j-1) for element (i,j), i=1 top row, j=1 leftmost column (maps to kernel dataij)
- win_last  out  1  qualifies win_valid: last window of the frame

## Operation
- Pixel accepted when pix_valid & pix_ready. pix_ready = ~win_valid | win_ready (combinational). It does not depend on whether the pixel completes a window.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the accepted pixel's position. col wraps to 0 after IMG_W-1 and row increments; after (IMG_H-1, IMG_W-1), both wrap to 0 and the next frame starts.
- Four line buffers of IMG_W bytes, indexed by col, hold rows r-4..r-1. On accept, the column shifts up (lb0<=lb1<=lb2<=lb3<=pix) at address col.
- 5x5 shift window: on accept, each row shifts left by one, and the new right column is {lb0[col], lb1[col], lb2[col], lb3[col], pix_data} (top to bottom).
- Window fires when the accepted pixel has row>=4 and col>=4. The window is then the pixels at rows row-4..row, cols col-4..col, so element (5,5) = the just-accepted pixel.
- Windows per frame: (IMG_W-4)*(IMG_H-4). win_last=1 only for the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
- Output register: loaded when a window fires; win_valid cleared on win_ready when no new window loads the same cycle. Simultaneous consume and load keeps win_valid=1 with the new data.
- Line buffer contents are never cleared. Stale data from a previous frame is never exposed, because windows require row>=4.
- clr: counters->0, win_valid->0, win_last->0. A pixel presented in the same cycle is dropped, and clr wins over any accept.

## Timing
- Reset values: win_valid=0, win_last=0, win_data=0, row=col=0, shift window=0. pix_ready=1 during and after reset.
- Latency: a window is visible on win_data/win_valid in the cycle after its bottom-right pixel is accepted.
- Throughput: 1 pixel/cycle sustained with win_ready held high.
- With win_valid=1 and win_ready=0, win_data/win_last are stable and pix_ready=0, so no pixel is lost.
- rst_n assertion mid-frame takes effect immediately. After release, the next accepted pixel is treated as (0,0).
- Counters advance only on accept. Idle cycles (pix_valid=0) change no state except the output consume.

## Test plan
- IMG_W=8, IMG_H=6, pixel value = 16*row+col, win_ready=1 -> exactly 8 windows. First window arrives 1 cycle after pixel (4,4) with byte0=0x00, byte4=0x04, byte20=0x40, byte24=0x44. Last window has byte24=0x57, byte0=0x13, win_last=1.
- Same stream with win_ready=0 for 10 cycles after the first window -> win_data stays at 0x44-window, pix_ready=0, and the pixel held on pix_data is accepted only after win_ready rises. The window sequence is identical to the unstalled run.
- Random pix_valid gaps (~50%) and random win_ready -> window sequence and values match the golden 8-window list, and win_last appears exactly once.
- Two back-to-back frames with no gap -> 16 windows. Frame-2 windows contain only frame-2 pixels, e.g. its first byte24 = 0x44 with byte0 = 0x00.
- clr asserted at pixel (3,2) of frame, then a full frame sent -> no window is emitted before the new (4,4), and the window values match a fresh frame.
- rst_n pulsed low while win_valid=1 -> win_valid=0, win_data=0 immediately, and the following full frame produces the correct 8 windows.
